// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for the shared 256-bit line memory port.
// Master 0 is the I-cache refill path, master 1 the D-cache. One whole
// transaction is granted at a time, followed by a one-cycle idle gap.
// A watchdog raises a sticky err_o when a BUSY transaction waits too long.
//
// Build option: define MEM_ARB_RR_EN for round-robin selection; otherwise
// fixed priority with master 1 winning contention.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; evaluate requests and latch a winner
// BUSY  | winner drives the memory port until mem_ack_i
// GAP   | one dead cycle so a master's stale request is not re-granted
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         m0_enable_i,
    input  logic         m0_write_i,
    input  logic [31:0]  m0_addr_i,
    input  logic [255:0] m0_data_i,
    output logic         m0_ack_o,
    output logic [255:0] m0_data_o,
    input  logic         m1_enable_i,
    input  logic         m1_write_i,
    input  logic [31:0]  m1_addr_i,
    input  logic [255:0] m1_data_i,
    output logic         m1_ack_o,
    output logic [255:0] m1_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_data_i,
    output logic [1:0]   grant_o,
    output logic         err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [1:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       err_q, err_d;
    logic [1:0] pick;
    logic       busy;

`ifdef MEM_ARB_RR_EN
    logic [1:0] last_q, last_d;

    // Round-robin pick: on contention the master not granted last wins
    always_comb begin
        pick = 2'b00;
        if (m0_enable_i && m1_enable_i) begin
            pick = last_q[0] ? 2'b10 : 2'b01;
        end else if (m1_enable_i) begin
            pick = 2'b10;
        end else if (m0_enable_i) begin
            pick = 2'b01;
        end
    end
`else
    // Fixed-priority pick: the D-cache (master 1) wins contention
    always_comb begin
        pick = 2'b00;
        if (m1_enable_i) begin
            pick = 2'b10;
        end else if (m0_enable_i) begin
            pick = 2'b01;
        end
    end
`endif

    // Next-state, grant and watchdog logic
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        wd_cnt_d = wd_cnt_q;
        err_d    = err_q;
`ifdef MEM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    state_d  = ST_BUSY;
                    grant_d  = pick;
                    wd_cnt_d = 8'd0;
`ifdef MEM_ARB_RR_EN
                    last_d   = pick;
`endif
                end
            end
            ST_BUSY: begin
                // An ack in the threshold cycle wins: no increment, no error
                if (mem_ack_i) begin
                    state_d = ST_GAP;
                    grant_d = 2'b00;
                end else if (wd_cnt_q != 8'hFF) begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                    if (wd_cnt_q + 8'd1 == WD_LIMIT) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            wd_cnt_q <= 8'd0;
            err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q   <= 2'b10;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
`ifdef MEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign busy = (state_q == ST_BUSY);

    // Memory port follows the granted master while BUSY, zero otherwise
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'd0;
        mem_data_o   = 256'd0;
        if (busy) begin
            mem_enable_o = 1'b1;
            if (grant_q[1]) begin
                mem_write_o = m1_write_i;
                mem_addr_o  = m1_addr_i;
                mem_data_o  = m1_data_i;
            end else if (grant_q[0]) begin
                mem_write_o = m0_write_i;
                mem_addr_o  = m0_addr_i;
                mem_data_o  = m0_data_i;
            end
        end
    end

    // Ack and read data return combinationally to the owner only
    always_comb begin
        m0_ack_o  = busy && grant_q[0] && mem_ack_i;
        m1_ack_o  = busy && grant_q[1] && mem_ack_i;
        m0_data_o = m0_ack_o ? mem_data_i : 256'd0;
        m1_data_o = m1_ack_o ? mem_data_i : 256'd0;
    end

    assign grant_o = busy ? grant_q : 2'b00;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a 10-cycle-latency memory model.
module tb_mem_arbiter;

    localparam logic [255:0] LINE0 =
        256'h8888_9999_7777_6666_5555_4444_3333_2222_eeee_ffff_dddd_cccc_bbbb_aaaa_1111_0000;
    localparam logic [255:0] ECFA_LINE = {16{16'hECFA}};

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [31:0]  m0_addr_i, m1_addr_i;
    logic [255:0] m0_data_i, m1_data_i;
    logic         m0_ack_o, m1_ack_o;
    logic [255:0] m0_data_o, m1_data_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;
    logic [1:0]   grant_o;
    logic         err_o;

    logic         mem_ack_en;
    logic         mem_ack_force;
    logic [255:0] mem_rdata;
    int           mem_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    // Memory model: ack in the 10th consecutive cycle of mem_enable_o
    always @(posedge clk_i) begin
        if (mem_enable_o && !mem_ack_i) mem_cnt <= mem_cnt + 1;
        else mem_cnt <= 0;
    end
    assign mem_ack_i  = mem_ack_force || (mem_ack_en && mem_enable_o && mem_cnt == 9);
    assign mem_data_i = mem_rdata;

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Waits (bounded) for any ack; n starts at the current cycle index
    task automatic wait_any_ack(input int start, output int n);
        n = start;
        while (!(m0_ack_o || m1_ack_o) && n < 60) begin
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        total++;
        if ({mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, m0_ack_o, m1_ack_o,
             m0_data_o, m1_data_o, grant_o, err_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: en=%b wr=%b addr=%h grant=%b err=%b acks=%b%b expected all zero",
                     mem_enable_o, mem_write_o, mem_addr_o, grant_o, err_o, m1_ack_o, m0_ack_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_single_read();
        int n;
        @(negedge clk_i);
        m0_addr_i = 32'h20; m0_write_i = 1'b0; m0_enable_i = 1'b1; mem_rdata = LINE0;
        #1;
        total++;
        if (mem_enable_o !== 1'b0) begin
            bad++; $display("FAIL read_no_comb_grant: mem_enable=%b expected 0", mem_enable_o);
        end
        @(negedge clk_i);
        total++;
        if ({mem_enable_o, grant_o, mem_write_o, mem_addr_o} !== {1'b1, 2'b01, 1'b0, 32'h20}) begin
            bad++;
            $display("FAIL read_busy: en=%b grant=%b wr=%b addr=%h expected 1 01 0 00000020",
                     mem_enable_o, grant_o, mem_write_o, mem_addr_o);
        end
        wait_any_ack(1, n);
        total++;
        if (n !== 10) begin
            bad++; $display("FAIL read_latency: ack cycle=%0d expected 10", n);
        end
        total++;
        if ({m1_ack_o, m0_ack_o} !== 2'b01 || m0_data_o !== LINE0 || m1_data_o !== 256'd0) begin
            bad++;
            $display("FAIL read_data: acks=%b m0_data=%h expected 01 %h", {m1_ack_o, m0_ack_o}, m0_data_o, LINE0);
        end
        m0_enable_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({m0_ack_o, mem_enable_o, grant_o} !== 4'b0 || m0_data_o !== 256'd0) begin
            bad++;
            $display("FAIL read_single_pulse: ack=%b en=%b grant=%b data=%h expected all zero",
                     m0_ack_o, mem_enable_o, grant_o, m0_data_o);
        end
    endtask

    task automatic test_gap();
        int n;
        @(negedge clk_i);
        m0_addr_i = 32'h60; m0_enable_i = 1'b1;
        @(negedge clk_i);
        wait_any_ack(1, n);
        total++;
        if (n !== 10) begin
            bad++; $display("FAIL gap_latency: ack cycle=%0d expected 10", n);
        end
        @(negedge clk_i);
        total++;
        if ({mem_enable_o, grant_o} !== 3'b000) begin
            bad++; $display("FAIL gap_cycle: en=%b grant=%b expected 0 00", mem_enable_o, grant_o);
        end
        @(negedge clk_i);
        total++;
        if (mem_enable_o !== 1'b0) begin
            bad++; $display("FAIL gap_no_regrant: en=%b expected 0", mem_enable_o);
        end
        m0_enable_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (mem_enable_o !== 1'b0) begin
            bad++; $display("FAIL gap_idle: en=%b expected 0", mem_enable_o);
        end
    endtask

    task automatic test_contention();
        int n;
        logic [1:0] first, second;
`ifdef MEM_ARB_RR_EN
        first = 2'b01; second = 2'b10;
`else
        first = 2'b10; second = 2'b01;
`endif
        do_reset();
        @(negedge clk_i);
        m0_addr_i = 32'h20; m0_write_i = 1'b0; m0_enable_i = 1'b1;
        m1_addr_i = 32'h40; m1_write_i = 1'b1; m1_data_i = ECFA_LINE; m1_enable_i = 1'b1;
        mem_rdata = LINE0;
        @(negedge clk_i);
        total++;
        if (grant_o !== first) begin
            bad++; $display("FAIL cont_first_grant: grant=%b expected %b", grant_o, first);
        end
        total++;
        if (first == 2'b10 ?
            {mem_write_o, mem_addr_o, mem_data_o} !== {1'b1, 32'h40, ECFA_LINE} :
            {mem_write_o, mem_addr_o, mem_data_o} !== {1'b0, 32'h20, 256'd0}) begin
            bad++;
            $display("FAIL cont_mem_port: wr=%b addr=%h data=%h for grant %b", mem_write_o, mem_addr_o, mem_data_o, first);
        end
        wait_any_ack(1, n);
        total++;
        if (n !== 10 || {m1_ack_o, m0_ack_o} !== first) begin
            bad++; $display("FAIL cont_first_ack: cycle=%0d acks=%b expected 10 %b", n, {m1_ack_o, m0_ack_o}, first);
        end
        if (first[0]) m0_enable_i = 1'b0; else m1_enable_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (mem_enable_o !== 1'b0) begin
            bad++; $display("FAIL cont_gap: en=%b expected 0", mem_enable_o);
        end
        @(negedge clk_i);
        total++;
        if (mem_enable_o !== 1'b0) begin
            bad++; $display("FAIL cont_idle: en=%b expected 0", mem_enable_o);
        end
        @(negedge clk_i);
        total++;
        if ({mem_enable_o, grant_o} !== {1'b1, second}) begin
            bad++; $display("FAIL cont_second_grant: en=%b grant=%b expected 1 %b", mem_enable_o, grant_o, second);
        end
        wait_any_ack(1, n);
        total++;
        if (n !== 10 || {m1_ack_o, m0_ack_o} !== second) begin
            bad++; $display("FAIL cont_second_ack: cycle=%0d acks=%b expected 10 %b", n, {m1_ack_o, m0_ack_o}, second);
        end
        m0_enable_i = 1'b0; m1_enable_i = 1'b0; m1_write_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        int n;
        logic [1:0] exp_g;
        do_reset();
        @(negedge clk_i);
        m0_addr_i = 32'h80; m0_write_i = 1'b0; m0_enable_i = 1'b1;
        m1_addr_i = 32'hA0; m1_write_i = 1'b0; m1_enable_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b10;
`endif
            n = 0;
            while (!mem_enable_o && n < 10) begin
                @(negedge clk_i);
                n++;
            end
            total++;
            if (grant_o !== exp_g) begin
                bad++; $display("FAIL b2b_grant[%0d]: grant=%b expected %b", t, grant_o, exp_g);
            end
            wait_any_ack(1, n);
            total++;
            if (n !== 10) begin
                bad++; $display("FAIL b2b_latency[%0d]: ack cycle=%0d expected 10", t, n);
            end
            @(negedge clk_i);
        end
        m0_enable_i = 1'b0; m1_enable_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_watchdog_ack_wins();
        do_reset();
        mem_ack_en = 1'b0;
        @(negedge clk_i);
        m0_addr_i = 32'h100; m0_enable_i = 1'b1;
        @(negedge clk_i);
        repeat (15) @(negedge clk_i);
        mem_ack_force = 1'b1;
        #1;
        total++;
        if (m0_ack_o !== 1'b1) begin
            bad++; $display("FAIL wd_tie_ack: ack=%b expected 1", m0_ack_o);
        end
        @(negedge clk_i);
        mem_ack_force = 1'b0; m0_enable_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL wd_tie_err: err=%b expected 0", err_o);
        end
    endtask

    task automatic test_watchdog();
        int n;
        mem_ack_en = 1'b0;
        mem_rdata = LINE0;
        @(negedge clk_i);
        m0_addr_i = 32'h120; m0_enable_i = 1'b1;
        @(negedge clk_i);
        n = 1;
        while (!err_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (n !== 17) begin
            bad++; $display("FAIL wd_rise: err seen in busy cycle=%0d expected 17", n);
        end
        repeat (5) @(negedge clk_i);
        total++;
        if ({err_o, mem_enable_o, m0_ack_o} !== 3'b110) begin
            bad++; $display("FAIL wd_hold: err=%b en=%b ack=%b expected 1 1 0", err_o, mem_enable_o, m0_ack_o);
        end
        mem_ack_force = 1'b1;
        #1;
        total++;
        if (m0_ack_o !== 1'b1 || m0_data_o !== LINE0) begin
            bad++; $display("FAIL wd_late_ack: ack=%b data=%h expected 1 %h", m0_ack_o, m0_data_o, LINE0);
        end
        @(negedge clk_i);
        mem_ack_force = 1'b0; m0_enable_i = 1'b0;
        total++;
        if ({err_o, mem_enable_o} !== 2'b10) begin
            bad++; $display("FAIL wd_sticky: err=%b en=%b expected 1 0", err_o, mem_enable_o);
        end
        mem_ack_en = 1'b1;
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk_i);
        m1_addr_i = 32'h140; m1_write_i = 1'b0; m1_enable_i = 1'b1;
        @(negedge clk_i);
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1; m1_enable_i = 1'b0;
        #1;
        total++;
        if ({mem_enable_o, grant_o, err_o, m1_ack_o, mem_addr_o} !== '0) begin
            bad++;
            $display("FAIL rst_busy_outputs: en=%b grant=%b err=%b ack=%b addr=%h expected all zero",
                     mem_enable_o, grant_o, err_o, m1_ack_o, mem_addr_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
        mem_ack_force = 1'b1;
        #1;
        total++;
        if ({m1_ack_o, m0_ack_o} !== 2'b00 || m1_data_o !== 256'd0) begin
            bad++; $display("FAIL rst_late_ack: acks=%b expected 00", {m1_ack_o, m0_ack_o});
        end
        @(negedge clk_i);
        mem_ack_force = 1'b0;
        total++;
        if ({mem_enable_o, grant_o} !== 3'b000) begin
            bad++; $display("FAIL rst_after_ack: en=%b grant=%b expected 0 00", mem_enable_o, grant_o);
        end
    endtask

    initial begin
        m0_enable_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
        mem_ack_en = 1'b1; mem_ack_force = 1'b0; mem_rdata = '0;
        test_reset();
        test_single_read();
        test_gap();
        test_contention();
        test_back_to_back();
        test_watchdog_ack_wins();
        test_watchdog();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
